lane_color_sched: RTL and testbench
===================================

# lane_color_sched

Per-pixel color scheduler for the note highway. Tracks a hit-flash / miss-dim effect timer for each lane, measured in frames. For every pixel it resolves the drawing layer and lane state into a `color_mode` / `color` code pair. That pair drives the downstream color_picker, so it owns every decision about which palette entry a pixel gets.

## Interface
- `NUM_LANES`, 5, number of note lanes (1..8); lane index = lane color code.
- `FLASH_FRAMES`, 8, frames a lane stays flashed after a good hit (1..255).
- `MISS_FRAMES`, 4, frames a lane stays dimmed after a miss (1..255).
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_start`  in  1  one-cycle pulse, once per frame.
- `hit_valid`  in  1  one-cycle judgement event.
- `hit_lane`  in  3  lane of the judgement.
- `hit_good`  in  1  1 = good hit, 0 = miss.
- `pix_valid`  in  1  pixel request this cycle.
- `pix_lane`  in  3  lane the pixel lies in.
- `pix_layer`  in  2  0 background, 1 track, 2 note, 3 strike line.
- `color_valid`  out  1  `pix_valid` delayed one cycle.
- `color_mode`  out  1  0 = BW, 1 = colored.
- `color`  out  3  palette code for color_picker.
- `lane_flash`  out  NUM_LANES  bit i = lane i in FLASH.
- `lane_dim`  out  NUM_LANES  bit i = lane i in DIM.

## Operation
- **Lane states and counters.** Each lane has a state (IDLE / FLASH / DIM) and a down-counter of width $clog2(max(FLASH_FRAMES, MISS_FRAMES)+1).
- **Judgement events.** When `hit_valid` is high and `hit_lane < NUM_LANES`:
  - `hit_good=1`: lane goes to FLASH and the counter loads `FLASH_FRAMES`.
  - `hit_good=0`: lane goes to DIM and the counter loads `MISS_FRAMES`.
  - Retriggers reload the counter from any state, including a switch between FLASH and DIM.
  - If `hit_lane >= NUM_LANES`, the event is ignored.
- **Frame countdown.** On `frame_start`, every non-IDLE lane decrements its counter. When a decrement takes the counter from 1 to 0, the lane enters IDLE in the same edge.
- **Simultaneous event and frame pulse.** If `hit_valid` and `frame_start` arrive together on the same lane, the event wins: the counter takes the full reload value and is not decremented.
- **Pixel resolution.** Each pixel is resolved from the lane state before the current edge's update. Codes:
  - Background → BW/000 (black).
  - Track, lane IDLE → BW/010 (gray).
  - Track, lane FLASH → BW/001 (white).
  - Track, lane DIM → BW/000 (black).
  - Note, lane not DIM → colored/lane index.
  - Note, lane DIM → BW/010.
  - Strike line, lane FLASH → colored/lane index.
  - Strike line, lane not FLASH → BW/001.
  - `pix_lane >= NUM_LANES`, any layer → BW/000.
- **Idle pixel cycles.** When `pix_valid=0`, `color_mode` and `color` hold their previous values.

## Timing
- **Reset values.** `color_valid`=0, `color_mode`=0, `color`=000, `lane_flash`=0, `lane_dim`=0, all lanes IDLE with counter 0.
- **Reset mid-effect.** Asserting reset during an effect clears it immediately, with no pulse required.
- **Pixel latency.** Pixel path latency is exactly 1 cycle; the block accepts one pixel per cycle with no stall.
- **Status latency.** `lane_flash` and `lane_dim` are registered and reflect the state after the edge that captured the event.
- **Effect duration.** A good hit followed by N `frame_start` pulses leaves the lane flashed until the Nth pulse with N = `FLASH_FRAMES`. The lane reads IDLE on the cycle after that edge.

## Configuration
- Feature macro: `LANE_COLOR_HIT_FLASH_EN`.
- **Defined:** behaviour exactly as described above.
- **Undefined:**
  - Good hits are ignored and FLASH is unreachable.
  - `lane_flash` is tied to 0.
  - Track pixels for a non-DIM lane are gray.
  - Strike-line pixels are always BW/001.
  - Miss-dim behaviour is unchanged.

## Structure
- **Package `lane_color_pkg`:**
  - Mode codes BW/COLORED.
  - BW codes BLACK=000, WHITE=001, GRAY=010.
  - Lane color codes GREEN=0, RED=1, YELLOW=2, BLUE=3, ORANGE=4.
  - Layer enum and lane-state enum (IDLE/FLASH/DIM).
- **Sub-module `lane_fx_timer`:** one instance per lane, holding state and counter. Inputs are `clk`, `rst_n`, `frame_start`, `trig_good` and `trig_miss`; outputs are the state.
- **Top level:** lane decode, pixel mux and the output register.

## Test plan
- **Reset output check.** Reset, then drive `pix_valid=1` with layer track on lane 2 → next cycle `color_valid=1`, BW/010.
- **Good-hit flash and expiry.** Good hit on lane 1, then track pixel on lane 1 → BW/001 and `lane_flash`=00010. After 8 `frame_start` pulses, `lane_flash`=0 and track pixel → BW/010.
- **Miss dim.** Miss on lane 3, then note pixel on lane 3 → BW/010; note pixel on lane 4 → colored/100. After 4 pulses, lane 3 note pixel → colored/011.
- **Simultaneous event and frame pulse.** Good hit on lane 0 in the same cycle as `frame_start` → the counter holds 8, and the lane stays FLASH for 8 more pulses.
- **Retrigger and state switch.** Good hit on lane 2 after 3 pulses → counter reloads to 8. A miss on lane 2 during FLASH → DIM with counter 4. `hit_lane`=6 → no state change.
- **Out-of-range lane and mid-effect reset.** Pixel with `pix_lane`=7, layer note → BW/000. Assert `rst_n` low mid-flash → `lane_flash`=0 immediately.

Source files
------------

// File: rtl/lane_color_pkg.sv
// Shared codes for the note-highway color scheduler: modes, palette codes, layers, lane states.
// Latency: none; types, constants and an elaboration-time helper only.
// Backpressure: none; nothing in this file carries flow control.
package lane_color_pkg;

   typedef enum logic {
      MODE_BW      = 1'b0,
      MODE_COLORED = 1'b1
   } color_mode_t;

   typedef enum logic [2:0] {
      BW_BLACK = 3'b000,
      BW_WHITE = 3'b001,
      BW_GRAY  = 3'b010
   } bw_code_t;

   // Lane index doubles as the lane's palette code on the colored path.
   typedef enum logic [2:0] {
      LANE_GREEN  = 3'd0,
      LANE_RED    = 3'd1,
      LANE_YELLOW = 3'd2,
      LANE_BLUE   = 3'd3,
      LANE_ORANGE = 3'd4
   } lane_color_t;

   typedef enum logic [1:0] {
      LAYER_BG     = 2'd0,
      LAYER_TRACK  = 2'd1,
      LAYER_NOTE   = 2'd2,
      LAYER_STRIKE = 2'd3
   } layer_t;

   typedef enum logic [1:0] {
      LANE_IDLE  = 2'd0,
      LANE_FLASH = 2'd1,
      LANE_DIM   = 2'd2
   } lane_state_t;

   // Counter width able to hold the longer of the two effect durations.
   function automatic int fx_cnt_width(input int flash_frames, input int miss_frames);
      int longest;
      longest = (flash_frames > miss_frames) ? flash_frames : miss_frames;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/lane_fx_timer.sv
// Per-lane effect timer: IDLE/FLASH/DIM state with a frame down-counter.
// Latency: a trigger or frame pulse is reflected in state one clock later.
// Backpressure: none; every trigger and frame pulse is absorbed the cycle it arrives.
module lane_fx_timer
   import lane_color_pkg::*;
#(
   parameter int FLASH_FRAMES = 8,
   parameter int MISS_FRAMES  = 4,
   parameter int CW           = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        trig_good,
   input  logic        trig_miss,
   output lane_state_t state
);

   lane_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // State and counter registers; reset drops any running effect at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LANE_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a trigger reloads from any state and beats a same-cycle frame pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (trig_good) begin
         state_d = LANE_FLASH;
         cnt_d   = CW'(FLASH_FRAMES);
      end else if (trig_miss) begin
         state_d = LANE_DIM;
         cnt_d   = CW'(MISS_FRAMES);
      end else if (frame_start && (state_q != LANE_IDLE)) begin
         if (cnt_q <= CW'(1)) begin
            state_d = LANE_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   assign state = state_q;

endmodule

// File: rtl/lane_color_sched.sv
// Per-pixel color scheduler: lane hit/miss effects resolved into color_mode/color codes.
// Latency: 1 cycle pixel-to-color, one pixel per cycle; lane status registered.
// Backpressure: none, never stalls. Build option LANE_COLOR_HIT_FLASH_EN enables hit flash.
module lane_color_sched
   import lane_color_pkg::*;
#(
   parameter int NUM_LANES    = 5,
   parameter int FLASH_FRAMES = 8,
   parameter int MISS_FRAMES  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic                 hit_valid,
   input  logic [2:0]           hit_lane,
   input  logic                 hit_good,
   input  logic                 pix_valid,
   input  logic [2:0]           pix_lane,
   input  logic [1:0]           pix_layer,
   output logic                 color_valid,
   output logic                 color_mode,
   output logic [2:0]           color,
   output logic [NUM_LANES-1:0] lane_flash,
   output logic [NUM_LANES-1:0] lane_dim
);

   localparam int CW = fx_cnt_width(FLASH_FRAMES, MISS_FRAMES);

`ifdef LANE_COLOR_HIT_FLASH_EN
   localparam bit FLASH_EN = 1'b1;
`else
   // Without hit flash, good hits never trigger and FLASH stays unreachable.
   localparam bit FLASH_EN = 1'b0;
`endif

   lane_state_t            lane_st [NUM_LANES];
   logic [NUM_LANES-1:0]   trig_good;
   logic [NUM_LANES-1:0]   trig_miss;
   logic [NUM_LANES-1:0]   st_flash;
   logic [NUM_LANES-1:0]   st_dim;
   lane_state_t            sel_state;
   logic                   sel_in_range;
   color_mode_t            mode_d;
   logic [2:0]             color_d;

   // Judgement decode; lanes at or above NUM_LANES match no timer and are dropped.
   always_comb begin
      trig_good = '0;
      trig_miss = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (hit_valid && (hit_lane == 3'(i))) begin
            trig_good[i] = FLASH_EN && hit_good;
            trig_miss[i] = !hit_good;
         end
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_fx_timer #(
         .FLASH_FRAMES (FLASH_FRAMES),
         .MISS_FRAMES  (MISS_FRAMES),
         .CW           (CW)
      ) u_fx (
         .clk         (clk),
         .rst_n       (rst_n),
         .frame_start (frame_start),
         .trig_good   (trig_good[g]),
         .trig_miss   (trig_miss[g]),
         .state       (lane_st[g])
      );
      assign st_flash[g] = (lane_st[g] == LANE_FLASH);
      assign st_dim[g]   = (lane_st[g] == LANE_DIM);
   end

   assign lane_flash = FLASH_EN ? st_flash : '0;
   assign lane_dim   = st_dim;

   // Pick the pixel lane's current (pre-edge) state; out-of-range lanes flag themselves.
   always_comb begin
      sel_state    = LANE_IDLE;
      sel_in_range = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (pix_lane == 3'(i)) begin
            sel_in_range = 1'b1;
            sel_state    = lane_st[i];
         end
      end
   end

   // Layer/state to palette mapping.
   always_comb begin
      mode_d  = MODE_BW;
      color_d = BW_BLACK;
      if (sel_in_range) begin
         case (layer_t'(pix_layer))
            LAYER_BG: begin
               color_d = BW_BLACK;
            end
            LAYER_TRACK: begin
               if (sel_state == LANE_DIM) begin
                  color_d = BW_BLACK;
               end else if (FLASH_EN && (sel_state == LANE_FLASH)) begin
                  color_d = BW_WHITE;
               end else begin
                  color_d = BW_GRAY;
               end
            end
            LAYER_NOTE: begin
               if (sel_state == LANE_DIM) begin
                  color_d = BW_GRAY;
               end else begin
                  mode_d  = MODE_COLORED;
                  color_d = pix_lane;
               end
            end
            default: begin
               if (FLASH_EN && (sel_state == LANE_FLASH)) begin
                  mode_d  = MODE_COLORED;
                  color_d = pix_lane;
               end else begin
                  color_d = BW_WHITE;
               end
            end
         endcase
      end
   end

   // Output register; color holds its last value across idle pixel cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color_valid <= 1'b0;
         color_mode  <= MODE_BW;
         color       <= BW_BLACK;
      end else begin
         color_valid <= pix_valid;
         if (pix_valid) begin
            color_mode <= mode_d;
            color      <= color_d;
         end
      end
   end

endmodule

// File: tb/tb_lane_color_sched.sv
// Self-checking bench for lane_color_sched: vector table, directed effect sequences, random traffic.
// Latency: expects colors one cycle after the pixel and status right after the capturing edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_lane_color_sched;

   localparam int NL = 5;
   localparam int FF = 8;
   localparam int MF = 4;

`ifdef LANE_COLOR_HIT_FLASH_EN
   localparam bit FLASH_EN = 1'b1;
`else
   localparam bit FLASH_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_start;
   logic          hit_valid;
   logic [2:0]    hit_lane;
   logic          hit_good;
   logic          pix_valid;
   logic [2:0]    pix_lane;
   logic [1:0]    pix_layer;
   logic          color_valid;
   logic          color_mode;
   logic [2:0]    color;
   logic [NL-1:0] lane_flash;
   logic [NL-1:0] lane_dim;

   int errors = 0;
   int checks = 0;

   // Reference: frames left and effect kind per lane (1 flash, 2 dim); 0 frames left = idle.
   int         m_left [8];
   int         m_kind [8];
   logic       exp_valid;
   logic [3:0] exp_pix;

   typedef struct {
      logic       fs;
      logic       hv;
      logic [2:0] hl;
      logic       hg;
      logic       pv;
      logic [2:0] pl;
      logic [1:0] ly;
      logic [3:0] epix;
      logic [4:0] edim;
   } vec_t;

   vec_t vt [16];

   lane_color_sched #(
      .NUM_LANES    (NL),
      .FLASH_FRAMES (FF),
      .MISS_FRAMES  (MF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .hit_valid   (hit_valid),
      .hit_lane    (hit_lane),
      .hit_good    (hit_good),
      .pix_valid   (pix_valid),
      .pix_lane    (pix_lane),
      .pix_layer   (pix_layer),
      .color_valid (color_valid),
      .color_mode  (color_mode),
      .color       (color),
      .lane_flash  (lane_flash),
      .lane_dim    (lane_dim)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] flash_mask();
      logic [4:0] m;
      m = '0;
      for (int l = 0; l < NL; l++) m[l] = (m_left[l] > 0) && (m_kind[l] == 1);
      return m;
   endfunction

   function automatic logic [4:0] dim_mask();
      logic [4:0] m;
      m = '0;
      for (int l = 0; l < NL; l++) m[l] = (m_left[l] > 0) && (m_kind[l] == 2);
      return m;
   endfunction

   // {mode, color} from the lane's effect as it stands before the edge.
   function automatic logic [3:0] ref_pix(input int lane, input int layer);
      logic fl, dm;
      if (lane >= NL) return 4'b0000;
      fl = (m_left[lane] > 0) && (m_kind[lane] == 1);
      dm = (m_left[lane] > 0) && (m_kind[lane] == 2);
      case (layer)
         0:       return 4'b0000;
         1:       return dm ? 4'b0000 : (fl ? 4'b0001 : 4'b0010);
         2:       return dm ? 4'b0010 : {1'b1, 3'(lane)};
         default: return fl ? {1'b1, 3'(lane)} : 4'b0001;
      endcase
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 8; l++) begin
         m_left[l] = 0;
         m_kind[l] = 0;
      end
      exp_valid = 1'b0;
      exp_pix   = 4'b0000;
   endtask

   // One clock: drive inputs, predict, clock, compare everything.
   task automatic step(input logic fs_i, input logic hv_i, input logic [2:0] hl_i,
                       input logic hg_i, input logic pv_i, input logic [2:0] pl_i,
                       input logic [1:0] ly_i);
      frame_start = fs_i;
      hit_valid   = hv_i;
      hit_lane    = hl_i;
      hit_good    = hg_i;
      pix_valid   = pv_i;
      pix_lane    = pl_i;
      pix_layer   = ly_i;
      exp_valid   = pv_i;
      if (pv_i) exp_pix = ref_pix(int'(pl_i), int'(ly_i));
      for (int l = 0; l < NL; l++) begin
         if (hv_i && (int'(hl_i) == l) && (!hg_i || FLASH_EN)) begin
            m_left[l] = hg_i ? FF : MF;
            m_kind[l] = hg_i ? 1 : 2;
         end else if (fs_i && (m_left[l] > 0)) begin
            m_left[l]--;
         end
      end
      @(posedge clk);
      #1;
      chk("color_valid", 32'(color_valid), 32'(exp_valid));
      chk("pixel", 32'({color_mode, color}), 32'(exp_pix));
      chk("lane_flash", 32'(lane_flash), 32'(flash_mask()));
      chk("lane_dim", 32'(lane_dim), 32'(dim_mask()));
   endtask

   task automatic tick(input logic fs_i);
      step(fs_i, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 2'd0);
   endtask

   task automatic pix(input logic [2:0] pl_i, input logic [1:0] ly_i);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, pl_i, ly_i);
   endtask

   task automatic hit(input logic [2:0] hl_i, input logic hg_i, input logic fs_i);
      step(fs_i, 1'b1, hl_i, hg_i, 1'b0, 3'd0, 2'd0);
   endtask

   initial begin
      // fs hv hl hg pv pl ly | {mode,color} dim
      vt[0]  = '{0, 0, 3'd0, 0, 1, 3'd2, 2'd1, 4'b0010, 5'b00000}; // track idle -> gray
      vt[1]  = '{0, 1, 3'd3, 0, 1, 3'd3, 2'd2, 4'b1011, 5'b01000}; // miss lane3, pixel sees pre-edge
      vt[2]  = '{0, 0, 3'd0, 0, 1, 3'd3, 2'd2, 4'b0010, 5'b01000}; // dimmed note -> gray
      vt[3]  = '{0, 0, 3'd0, 0, 1, 3'd4, 2'd2, 4'b1100, 5'b01000}; // other lane note colored
      vt[4]  = '{0, 0, 3'd0, 0, 1, 3'd3, 2'd1, 4'b0000, 5'b01000}; // dimmed track -> black
      vt[5]  = '{0, 0, 3'd0, 0, 1, 3'd3, 2'd3, 4'b0001, 5'b01000}; // strike -> white
      vt[6]  = '{0, 0, 3'd0, 0, 0, 3'd0, 2'd2, 4'b0001, 5'b01000}; // idle pixel holds
      vt[7]  = '{0, 0, 3'd0, 0, 1, 3'd0, 2'd0, 4'b0000, 5'b01000}; // background
      vt[8]  = '{0, 0, 3'd0, 0, 1, 3'd7, 2'd2, 4'b0000, 5'b01000}; // lane 7 note -> black
      vt[9]  = '{1, 0, 3'd0, 0, 1, 3'd3, 2'd1, 4'b0000, 5'b01000}; // pulse 1
      vt[10] = '{1, 0, 3'd0, 0, 1, 3'd1, 2'd2, 4'b1001, 5'b01000}; // pulse 2
      vt[11] = '{1, 0, 3'd0, 0, 1, 3'd0, 2'd3, 4'b0001, 5'b01000}; // pulse 3
      vt[12] = '{1, 0, 3'd0, 0, 1, 3'd3, 2'd2, 4'b0010, 5'b00000}; // pulse 4 expires dim
      vt[13] = '{0, 0, 3'd0, 0, 1, 3'd3, 2'd2, 4'b1011, 5'b00000}; // lane3 colored again
      vt[14] = '{0, 1, 3'd6, 0, 1, 3'd5, 2'd2, 4'b0000, 5'b00000}; // hit lane 6 ignored
      vt[15] = '{1, 1, 3'd0, 0, 1, 3'd0, 2'd2, 4'b1000, 5'b00001}; // miss + pulse same cycle

      frame_start = 1'b0;
      hit_valid   = 1'b0;
      hit_lane    = 3'd0;
      hit_good    = 1'b0;
      pix_valid   = 1'b0;
      pix_lane    = 3'd0;
      pix_layer   = 2'd0;
      rst_n       = 1'b1;
      model_reset();

      // Reset values while reset is held.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_color_valid", 32'(color_valid), 32'd0);
      chk("rst_color_mode", 32'(color_mode), 32'd0);
      chk("rst_color", 32'(color), 32'd0);
      chk("rst_lane_flash", 32'(lane_flash), 32'd0);
      chk("rst_lane_dim", 32'(lane_dim), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Vector table.
      for (int i = 0; i < 16; i++) begin
         step(vt[i].fs, vt[i].hv, vt[i].hl, vt[i].hg, vt[i].pv, vt[i].pl, vt[i].ly);
         chk($sformatf("vec%0d_pix", i), 32'({color_mode, color}), 32'(vt[i].epix));
         chk($sformatf("vec%0d_valid", i), 32'(color_valid), 32'(vt[i].pv));
         chk($sformatf("vec%0d_dim", i), 32'(lane_dim), 32'(vt[i].edim));
      end

      // Good-hit flash on lane 1 and expiry after FF pulses.
      hit(3'd1, 1'b1, 1'b0);
      pix(3'd1, 2'd1);
      chk("hit_track_pix", 32'({color_mode, color}), FLASH_EN ? 32'h1 : 32'h2);
      chk("hit_flash_bits", 32'(lane_flash), FLASH_EN ? 32'h02 : 32'h00);
      for (int i = 0; i < FF - 1; i++) tick(1'b1);
      chk("flash_before_last", 32'(lane_flash[1]), 32'(FLASH_EN));
      tick(1'b1);
      chk("flash_after_last", 32'(lane_flash), 32'd0);
      pix(3'd1, 2'd1);
      chk("expired_track_pix", 32'({color_mode, color}), 32'h2);

      // Good hit coinciding with a frame pulse: full reload, no decrement.
      hit(3'd0, 1'b1, 1'b1);
      for (int i = 0; i < FF - 1; i++) tick(1'b1);
      chk("simul_flash_held", 32'(lane_flash[0]), 32'(FLASH_EN));
      pix(3'd0, 2'd3);
      tick(1'b1);
      chk("simul_flash_done", 32'(lane_flash[0]), 32'd0);

      // Retrigger on lane 2, then switch to dim, then an out-of-range hit.
      hit(3'd2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1);
      hit(3'd2, 1'b1, 1'b0);
      for (int i = 0; i < FF - 1; i++) tick(1'b1);
      chk("retrig_flash_held", 32'(lane_flash[2]), 32'(FLASH_EN));
      hit(3'd2, 1'b0, 1'b0);
      chk("switch_to_dim", 32'({lane_dim[2], lane_flash[2]}), 32'b10);
      for (int i = 0; i < MF - 1; i++) tick(1'b1);
      hit(3'd6, 1'b1, 1'b0);
      chk("lane6_no_change", 32'(lane_dim), 32'h04);
      tick(1'b1);
      chk("dim_expired", 32'(lane_dim), 32'd0);

      // Randomized traffic against the reference.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0), 3'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
      end

      // Reset in the middle of running effects clears them without a clock.
      hit(3'd4, 1'b0, 1'b0);
      hit(3'd2, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_flash", 32'(lane_flash), 32'd0);
      chk("midrst_dim", 32'(lane_dim), 32'd0);
      chk("midrst_valid", 32'(color_valid), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      pix(3'd4, 2'd2);
      chk("post_rst_note", 32'({color_mode, color}), 32'hC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
